// File: rtl/stream_join_buffered.sv
// stream_join_buffered: N-way join with a small FIFO per input lane.
// The joined output fires once every selected lane holds a word.
module stream_join_buffered #(
  parameter int N_INP      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [N_INP-1:0]            sel_i,
  input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
  input  logic [N_INP-1:0]            inp_valid_i,
  output logic [N_INP-1:0]            inp_ready_o,
  output logic [N_INP*DATA_WIDTH-1:0] oup_data_o,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [N_INP*CNT_W-1:0]      usage_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [N_INP][DEPTH];
  logic [PTR_W-1:0]      r_wptr [N_INP];
  logic [PTR_W-1:0]      r_rptr [N_INP];
  logic [CNT_W-1:0]      r_cnt [N_INP];

  logic [N_INP-1:0] w_have;
  logic [N_INP-1:0] w_push;
  logic [N_INP-1:0] w_pop;
  logic             w_fire;

  // Per-lane status: ready, occupancy and masked head word.
  always_comb begin
    w_have      = '0;
    inp_ready_o = '0;
    usage_o     = '0;
    oup_data_o  = '0;
    for (int i = 0; i < N_INP; i++) begin
      w_have[i]      = (r_cnt[i] != '0);
      inp_ready_o[i] = (r_cnt[i] != FULL) && !flush_i;
      usage_o[i*CNT_W +: CNT_W] = r_cnt[i];
      if (w_have[i])
        oup_data_o[i*DATA_WIDTH +: DATA_WIDTH] =
          r_mem[i][r_rptr[i]];
    end
  end

  assign w_push = inp_valid_i & inp_ready_o;

  // Unselected lanes are treated as satisfied; an empty
  // selection never fires.
  assign oup_valid_o = (sel_i != '0) &&
                       ((w_have | ~sel_i) == '1) &&
                       !flush_i;
  assign w_fire = oup_valid_o && oup_ready_i;
  assign w_pop  = w_fire ? sel_i : '0;

  // Payload storage; left unreset since empty lanes read as zero.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_INP; i++)
      if (w_push[i])
        r_mem[i][r_wptr[i]] <=
          inp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Pointer and fill-count bookkeeping; flush beats push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_INP; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < N_INP; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_INP; i++) begin
        if (w_push[i])
          r_wptr[i] <= (r_wptr[i] == LAST) ?
                       '0 : r_wptr[i] + 1'b1;
        if (w_pop[i])
          r_rptr[i] <= (r_rptr[i] == LAST) ?
                       '0 : r_rptr[i] + 1'b1;
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  if (N_INP < 1) begin : g_bad_n_inp
    $error("N_INP must be at least 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("DEPTH must be at least 1");
  end

  logic             r_stall;
  logic [N_INP-1:0] r_sel_q;

  // Sanity checks on FIFO usage and on sel_i during a stall.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall <= 1'b0;
      r_sel_q <= '0;
    end else begin
      r_stall <= oup_valid_o && !oup_ready_i;
      r_sel_q <= sel_i;
      for (int i = 0; i < N_INP; i++) begin
        assert (!(w_pop[i] && r_cnt[i] == '0))
          else $error("pop from empty lane %0d", i);
        assert (!(w_push[i] && r_cnt[i] == FULL))
          else $error("push into full lane %0d", i);
      end
      assert (!r_stall || sel_i == r_sel_q)
        else $error("sel_i changed while output stalled");
    end
  end
`endif

endmodule

// File: tb/tb_stream_join_buffered.sv
// tb_stream_join_buffered: directed scenarios with a
// per-test scoreboard of joined words.
module tb_stream_join_buffered;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [N-1:0]  sel;
  logic [N*W-1:0] idata;
  logic [N-1:0]  ival;
  logic [N-1:0]  irdy;
  logic [N*W-1:0] odata;
  logic          oval;
  logic          ordy;
  logic [N*CW-1:0] usage;

  int total;
  int bad;

  stream_join_buffered #(
    .N_INP(N),
    .DATA_WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .sel_i(sel),
    .inp_data_i(idata),
    .inp_valid_i(ival),
    .inp_ready_o(irdy),
    .oup_data_o(odata),
    .oup_valid_o(oval),
    .oup_ready_i(ordy),
    .usage_o(usage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] word(int k);
    logic [7:0] b;
    b = 8'(k);
    return {~b, b ^ 8'h5A, b};
  endfunction

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    total++;
    if (irdy !== 3'b111) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=111", irdy);
    end
    total++;
    if (oval !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b exp=0", oval);
    end
    total++;
    if (usage !== 6'd0) begin
      bad++;
      $display("FAIL rst_usage got=%h exp=0", usage);
    end
    total++;
    if (odata !== 24'd0) begin
      bad++;
      $display("FAIL rst_data got=%h exp=0", odata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_join();
    logic [23:0] sb[$];
    logic [23:0] exp;
    sel = 3'b111; ordy = 1'b0;
    ival = 3'b001; idata = 24'h0000A1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ival = 3'b000;
    @(negedge clk);
    total++;
    if (usage[1:0] !== 2'd2) begin
      bad++;
      $display("FAIL join_usage0 got=%0d exp=2", usage[1:0]);
    end
    total++;
    if (irdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL join_full_ready got=%b exp=0", irdy[0]);
    end
    total++;
    if (oval !== 1'b0) begin
      bad++;
      $display("FAIL join_early_valid got=%b exp=0", oval);
    end
    @(posedge clk); #1;
    ival = 3'b110; idata = 24'hC1B100;
    sb.push_back(24'hC1B1A1);
    @(negedge clk);
    total++;
    if (oval !== 1'b0) begin
      bad++;
      $display("FAIL join_no_fallthru got=%b exp=0", oval);
    end
    @(posedge clk); #1;
    ival = 3'b000; ordy = 1'b1;
    @(negedge clk);
    total++;
    if (oval !== 1'b1) begin
      bad++;
      $display("FAIL join_valid got=%b exp=1", oval);
    end
    if (oval) begin
      exp = sb.pop_front();
      total++;
      if (odata !== exp) begin
        bad++;
        $display("FAIL join_data got=%h exp=%h", odata, exp);
      end
    end
    @(posedge clk); #1;
    ordy = 1'b0;
    @(negedge clk);
    total++;
    if (usage !== 6'b00_00_01) begin
      bad++;
      $display("FAIL join_usage_after got=%b exp=000001", usage);
    end
    total++;
    if (odata !== 24'h0000A1) begin
      bad++;
      $display("FAIL join_head got=%h exp=0000a1", odata);
    end
    total++;
    if (oval !== 1'b0) begin
      bad++;
      $display("FAIL join_valid_after got=%b exp=0", oval);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_sel();
    logic [15:0] sb[$];
    logic [15:0] exp;
    do_flush();
    sel = 3'b101; ordy = 1'b0;
    ival = 3'b111; idata = 24'h335511;
    sb.push_back(16'h3311);
    @(posedge clk); #1;
    ival = 3'b000; ordy = 1'b1;
    @(negedge clk);
    total++;
    if (oval !== 1'b1) begin
      bad++;
      $display("FAIL psel_valid got=%b exp=1", oval);
    end
    if (oval) begin
      exp = sb.pop_front();
      total++;
      if ({odata[23:16], odata[7:0]} !== exp) begin
        bad++;
        $display("FAIL psel_data got=%h exp=%h",
                 {odata[23:16], odata[7:0]}, exp);
      end
    end
    @(posedge clk); #1;
    ordy = 1'b0;
    @(negedge clk);
    total++;
    if (usage !== 6'b00_01_00) begin
      bad++;
      $display("FAIL psel_usage got=%b exp=000100", usage);
    end
    total++;
    if (odata !== 24'h005500) begin
      bad++;
      $display("FAIL psel_keep got=%h exp=005500", odata);
    end
    total++;
    if (oval !== 1'b0) begin
      bad++;
      $display("FAIL psel_valid_after got=%b exp=0", oval);
    end
    @(posedge clk); #1;
    sel = 3'b000; ordy = 1'b1;
    @(negedge clk);
    total++;
    if (oval !== 1'b0) begin
      bad++;
      $display("FAIL psel_zero_sel got=%b exp=0", oval);
    end
    @(posedge clk); #1;
    ordy = 1'b0; sel = 3'b111;
    @(negedge clk);
    total++;
    if (usage !== 6'b00_01_00) begin
      bad++;
      $display("FAIL psel_zero_nopop got=%b exp=000100", usage);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic [23:0] sb[$];
    logic [23:0] exp;
    int k, hs, first_c, last_c;
    do_flush();
    sel = 3'b111; ordy = 1'b1;
    k = 0; hs = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 200 && hs < 100; c++) begin
      if (k < 100) begin
        ival = 3'b111; idata = word(k);
      end else begin
        ival = 3'b000;
      end
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (oval !== 1'b0) begin
          bad++;
          $display("FAIL stream_fill got=%b exp=0", oval);
        end
      end
      if (oval === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL stream_extra got=%h exp=none", odata);
        end else begin
          exp = sb.pop_front();
          if (odata !== exp) begin
            bad++;
            $display("FAIL stream_data got=%h exp=%h", odata, exp);
          end
        end
        hs++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (k < 100 && irdy == 3'b111) begin
        sb.push_back(word(k));
        k++;
      end
      @(posedge clk); #1;
    end
    ival = 3'b000; ordy = 1'b0;
    total++;
    if (hs != 100) begin
      bad++;
      $display("FAIL stream_count got=%0d exp=100", hs);
    end
    total++;
    if (first_c != 1) begin
      bad++;
      $display("FAIL stream_latency got=%0d exp=1", first_c);
    end
    total++;
    if (last_c - first_c != 99) begin
      bad++;
      $display("FAIL stream_rate got=%0d exp=99",
               last_c - first_c);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL stream_left got=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] sb[$];
    logic [23:0] exp;
    do_flush();
    sel = 3'b111; ordy = 1'b0;
    ival = 3'b111; idata = 24'h030201;
    sb.push_back(24'h030201);
    @(posedge clk); #1;
    idata = 24'h131211;
    sb.push_back(24'h131211);
    @(posedge clk); #1;
    ival = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (oval !== 1'b1) begin
        bad++;
        $display("FAIL bp_valid got=%b exp=1", oval);
      end
      total++;
      if (odata !== sb[0]) begin
        bad++;
        $display("FAIL bp_data got=%h exp=%h", odata, sb[0]);
      end
      total++;
      if (irdy !== 3'b000) begin
        bad++;
        $display("FAIL bp_ready got=%b exp=000", irdy);
      end
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      total++;
      if (oval !== 1'b1) begin
        bad++;
        $display("FAIL bp_resume_valid got=%b exp=1", oval);
      end
      if (oval === 1'b1) begin
        exp = sb.pop_front();
        total++;
        if (odata !== exp) begin
          bad++;
          $display("FAIL bp_resume_data got=%h exp=%h", odata, exp);
        end
      end
      if (j == 1) begin
        total++;
        if (irdy !== 3'b111) begin
          bad++;
          $display("FAIL bp_ready_back got=%b exp=111", irdy);
        end
      end
      @(posedge clk); #1;
    end
    ordy = 1'b0;
    @(negedge clk);
    total++;
    if (usage !== 6'd0 || oval !== 1'b0) begin
      bad++;
      $display("FAIL bp_drained got=%b/%b exp=000000/0", usage, oval);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    do_flush();
    sel = 3'b111; ordy = 1'b0;
    ival = 3'b111; idata = 24'h414243;
    @(posedge clk); #1;
    ival = 3'b101;
    @(posedge clk); #1;
    ival = 3'b000;
    @(negedge clk);
    total++;
    if (usage !== 6'b10_01_10) begin
      bad++;
      $display("FAIL fl_usage_pre got=%b exp=100110", usage);
    end
    total++;
    if (oval !== 1'b1) begin
      bad++;
      $display("FAIL fl_valid_pre got=%b exp=1", oval);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (irdy !== 3'b000) begin
      bad++;
      $display("FAIL fl_ready got=%b exp=000", irdy);
    end
    total++;
    if (oval !== 1'b0) begin
      bad++;
      $display("FAIL fl_valid got=%b exp=0", oval);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (usage !== 6'd0) begin
      bad++;
      $display("FAIL fl_usage got=%b exp=000000", usage);
    end
    total++;
    if (oval !== 1'b0 || odata !== 24'd0) begin
      bad++;
      $display("FAIL fl_out got=%b/%h exp=0/000000", oval, odata);
    end
    total++;
    if (irdy !== 3'b111) begin
      bad++;
      $display("FAIL fl_ready_after got=%b exp=111", irdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    sel = 3'b111; ordy = 1'b0;
    ival = 3'b111; idata = 24'hABCDEF;
    @(posedge clk); #1;
    ival = 3'b000;
    @(negedge clk);
    total++;
    if (usage !== 6'b01_01_01) begin
      bad++;
      $display("FAIL rm_usage_pre got=%b exp=010101", usage);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (usage !== 6'd0) begin
      bad++;
      $display("FAIL rm_usage got=%b exp=000000", usage);
    end
    total++;
    if (oval !== 1'b0 || odata !== 24'd0) begin
      bad++;
      $display("FAIL rm_out got=%b/%h exp=0/000000", oval, odata);
    end
    total++;
    if (irdy !== 3'b111) begin
      bad++;
      $display("FAIL rm_ready got=%b exp=111", irdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ival = 3'b001; idata = 24'h000077;
    @(negedge clk);
    total++;
    if (irdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL rm_first_ready got=%b exp=1", irdy[0]);
    end
    @(posedge clk); #1;
    ival = 3'b000;
    @(negedge clk);
    total++;
    if (usage !== 6'b00_00_01) begin
      bad++;
      $display("FAIL rm_first_push got=%b exp=000001", usage);
    end
    total++;
    if (odata !== 24'h000077) begin
      bad++;
      $display("FAIL rm_first_data got=%h exp=000077", odata);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; flush = 1'b0; sel = 3'b111;
    idata = '0; ival = '0; ordy = 1'b0;
    test_reset();
    test_join();
    test_partial_sel();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
